pdm_demod: RTL and testbench

- Demodulates a 1-bit pulse-density-modulated stream back to an NBITS-wide unsigned sample. It is the receive-side counterpart of the team's first-order sigma-delta PDM modulator.
- Uses a boxcar decimator: counts ones over a window of 2^WIN_LOG2 enabled clocks, scales the count to NBITS, and emits one sample per window with a single-cycle valid strobe.
- Used for loopback checking of the PDM DAC path and for reading PDM-coded inputs into the AXI register space.

---
 rtl/pdm_demod.sv | 61 ++++++
 tb/tb_pdm_demod.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pdm_demod.sv
// Boxcar PDM demodulator: counts ones over 2^WIN_LOG2 enabled samples and
// emits the count scaled to NBITS bits once per window.
module pdm_demod #(
    parameter int NBITS    = 10,
    parameter int WIN_LOG2 = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             din,
    output logic [NBITS-1:0] dout,
    output logic             valid,
    output logic             busy
);

    localparam int SHIFT = NBITS - WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

    logic [WIN_LOG2-1:0] cnt;
    logic [WIN_LOG2:0]   acc;
    logic [WIN_LOG2:0]   total;
    logic [NBITS-1:0]    scaled;
    logic                last;

    // total can only reach 2^WIN_LOG2 when every bit of the window was one;
    // that single value would overflow the shift, so it clamps to full scale.
    always_comb begin
        last   = en && (cnt == CNT_LAST);
        total  = acc + (WIN_LOG2+1)'(din);
        scaled = NBITS'(total[WIN_LOG2-1:0]) << SHIFT;
        if (total[WIN_LOG2]) begin
            scaled = '1;
        end
    end

    // valid is a one-cycle strobe with no backpressure: dout changes only on
    // the cycle valid is high and holds until the next strobe.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt   <= '0;
            acc   <= '0;
            dout  <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (last) begin
                cnt   <= '0;
                acc   <= '0;
                busy  <= 1'b0;
                dout  <= scaled;
                valid <= 1'b1;
            end else if (en) begin
                cnt  <= cnt + WIN_LOG2'(1);
                acc  <= total;
                busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pdm_demod.sv
// Directed bench for pdm_demod: a driver pushes expected strobes into
// queues and negedge monitors pop and compare whenever valid is seen.
module tb_pdm_demod;

    localparam int NBITS = 10;
    localparam int WIN   = 1024;
    localparam int WIN4  = 16;

    logic             clk;
    logic             resetn;
    logic             en, din, en4, din4;
    logic [NBITS-1:0] dout, dout4;
    logic             valid, busy, valid4, busy4;

    pdm_demod #(.NBITS(NBITS), .WIN_LOG2(10)) u_dut (
        .clk(clk), .resetn(resetn), .en(en), .din(din),
        .dout(dout), .valid(valid), .busy(busy)
    );

    pdm_demod #(.NBITS(NBITS), .WIN_LOG2(4)) u_dut4 (
        .clk(clk), .resetn(resetn), .en(en4), .din(din4),
        .dout(dout4), .valid(valid4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int n_main = 0;
    int n4     = 0;
    logic last_en  = 1'b0;
    logic last_en4 = 1'b0;

    logic [NBITS-1:0] cur_exp = '0;
    int               cur_tol = 0;

    logic [NBITS-1:0] exp_q[$];
    int               tol_q[$];
    int               edge_q[$];
    logic [NBITS-1:0] exp4_q[$];
    int               edge4_q[$];

    logic [10:0] mod_acc = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edges);
        end
    endtask

    // One clock edge of stimulus; records when each DUT should strobe.
    task automatic step(input logic e, input logic d, input logic e4,
                        input logic d4, input logic rn);
        en = e; din = d; en4 = e4; din4 = d4; resetn = rn;
        @(posedge clk);
        edges++;
        last_en  = e;
        last_en4 = e4;
        if (!rn) begin
            n_main = 0;
            n4     = 0;
        end else begin
            if (e) begin
                n_main++;
                if (n_main % WIN == 0) begin
                    exp_q.push_back(cur_exp);
                    tol_q.push_back(cur_tol);
                    edge_q.push_back(edges);
                end
            end
            if (e4) begin
                n4++;
                if (n4 % WIN4 == 0) begin
                    exp4_q.push_back(NBITS'(320));
                    edge4_q.push_back(edges);
                end
            end
        end
        #1;
        if (rn) begin
            chk("busy", int'(busy), int'(n_main % WIN != 0));
            chk("busy4", int'(busy4), int'(n4 % WIN4 != 0));
        end
    endtask

    task automatic mod_step(input int d);
        logic [10:0] sum;
        sum = {1'b0, mod_acc[9:0]} + 11'(d);
        mod_acc = {1'b0, sum[9:0]};
        step(1'b1, sum[10], 1'b0, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (valid) begin
            checks++;
            if (!last_en) begin
                errors++;
                $display("FAIL valid_after_en_low: valid=1 at edge %0d, expected 0", edges);
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: dout=%0d at edge %0d, expected no strobe", dout, edges);
            end else begin
                logic [NBITS-1:0] e;
                int t, ed, diff;
                e  = exp_q.pop_front();
                t  = tol_q.pop_front();
                ed = edge_q.pop_front();
                diff = int'(dout) - int'(e);
                if (diff < 0) diff = -diff;
                checks++;
                if (diff > t) begin
                    errors++;
                    $display("FAIL dout: got %0d expected %0d (+/-%0d) at edge %0d", dout, e, t, edges);
                end
                chk("strobe_edge", edges, ed);
            end
        end
        if (valid4) begin
            if (exp4_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe4: dout4=%0d at edge %0d, expected no strobe", dout4, edges);
            end else begin
                logic [NBITS-1:0] e4;
                int ed4;
                e4  = exp4_q.pop_front();
                ed4 = edge4_q.pop_front();
                chk("dout4", int'(dout4), int'(e4));
                chk("strobe_edge4", edges, ed4);
            end
        end
    end

    initial begin
        logic [15:0] pat4;
        pat4 = 16'h1249;
        en = 1'b0; din = 1'b0; en4 = 1'b0; din4 = 1'b0; resetn = 1'b0;

        // Reset state
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("reset_dout", int'(dout), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_dout4", int'(dout4), 0);

        // Constant zero stream: three windows of 0
        cur_exp = '0; cur_tol = 0;
        repeat (3 * WIN) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Constant one stream: saturates to 1023
        cur_exp = 10'd1023;
        repeat (2 * WIN) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Alternating enable, 3-of-8 ones on enabled samples, din=1 while disabled
        cur_exp = 10'd384;
        for (int k = 0; k < 2 * WIN; k++) begin
            step(1'b1, logic'((k % 8) < 3), 1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        end

        // Short window instance: 5 ones per 16 -> 5 << 6 = 320
        for (int i = 0; i < 4 * WIN4; i++) begin
            step(1'b0, 1'b0, 1'b1, pat4[i % 16], 1'b1);
        end
        chk("hold_dout_en_low", int'(dout), 384);

        // Loopback with a first-order modulator released on the same edge
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mod_acc = '0;
        cur_exp = 10'd120; cur_tol = 0;
        repeat (WIN) mod_step(120);
        cur_exp = 10'd500; cur_tol = 1;
        repeat (2 * WIN) mod_step(500);
        cur_exp = 10'd900; cur_tol = 1;
        repeat (2 * WIN) mod_step(900);

        // Reset at enabled sample 500 of a window discards it
        cur_exp = 10'd1023; cur_tol = 0;
        repeat (500) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("pre_reset_busy", int'(busy), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("midreset_dout", int'(dout), 0);
        chk("midreset_valid", int'(valid), 0);
        chk("midreset_busy", int'(busy), 0);
        cur_exp = 10'd200;
        for (int k = 0; k < WIN; k++) begin
            step(1'b1, logic'(k < 200), 1'b0, 1'b0, 1'b1);
        end

        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pending_strobes", exp_q.size(), 0);
        chk("pending_strobes4", exp4_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
